// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and constants for the operand-2 barrel shifter
package shifter_pkg;

   localparam int WORD_W  = 32;
   localparam int SHAMT_W = 5;
   localparam int AMT_W   = 8;

   typedef enum logic [1:0] {
      LSL = 2'b00,
      LSR = 2'b01,
      ASR = 2'b10,
      ROR = 2'b11
   } shift_type_t;

   // Immediate forms only carry a 5-bit amount; the upper bits of the field
   // belong to other instruction fields and must not leak into the amount.
   function automatic logic [AMT_W-1:0] effective_amount(
      input logic             instr4,
      input logic [AMT_W-1:0] shift_num
   );
      if (instr4) begin
         return shift_num;
      end
      return {3'b000, shift_num[SHAMT_W-1:0]};
   endfunction

endpackage

// File: rtl/shifter_if.sv
// rtl/shifter_if.sv - operand-2 shifter request/result bundle
interface shifter_if;
   import shifter_pkg::*;

   shift_type_t              shift_type;
   logic [AMT_W-1:0]         shift_num;
   logic                     not_shift;
   logic                     instr4;
   logic [WORD_W-1:0]        x;
   logic                     carry;
   logic [WORD_W-1:0]        y;
   logic                     c;
   logic [WORD_W-1:0]        y_q;
   logic                     c_q;

   // Decode stage drives the request and consumes the results.
   modport master (
      output shift_type, shift_num, not_shift, instr4, x, carry,
      input  y, c, y_q, c_q
   );

   // Shifter receives the request and produces the results.
   modport slave (
      input  shift_type, shift_num, not_shift, instr4, x, carry,
      output y, c, y_q, c_q
   );

endinterface

// File: rtl/shifter_rotate_right32.sv
// rtl/shifter_rotate_right32.sv - 32-bit log-staged rotate-right
module rotate_right32
   import shifter_pkg::*;
(
   input  logic [WORD_W-1:0]  x_i,
   input  logic [SHAMT_W-1:0] amt_i,
   output logic [WORD_W-1:0]  y_o
);

   logic [WORD_W-1:0] s1, s2, s4, s8;

   // Five binary-weighted rotate stages; an amount of zero passes x through.
   always_comb begin
      s1  = amt_i[0] ? {x_i[0],    x_i[31:1]} : x_i;
      s2  = amt_i[1] ? {s1[1:0],   s1[31:2]}  : s1;
      s4  = amt_i[2] ? {s2[3:0],   s2[31:4]}  : s2;
      s8  = amt_i[3] ? {s4[7:0],   s4[31:8]}  : s4;
      y_o = amt_i[4] ? {s8[15:0],  s8[31:16]} : s8;
   end

endmodule

// File: rtl/shifter.sv
// rtl/shifter.sv - ARM operand-2 barrel shifter with carry-out and registered copy
module shifter
   import shifter_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   shifter_if.slave bus
);

   logic [AMT_W-1:0]   n;
   logic [SHAMT_W-1:0] r;
   logic [SHAMT_W-1:0] r_m1;
   logic [SHAMT_W-1:0] r_neg;
   logic               n_zero;
   logic               n_big;
   logic               n_eq32;
   logic               is_rrx;
   logic [WORD_W-1:0]  rot_y;
   logic [WORD_W-1:0]  y_d;
   logic               c_d;
   logic [WORD_W-1:0]  y_q_q;
   logic               c_q_q;

   // Amount decode: r is the in-word amount, r_m1 indexes the last bit shifted
   // out to the right, r_neg (32-r mod 32) the last bit shifted out to the left.
   always_comb begin
      n      = effective_amount(bus.instr4, bus.shift_num);
      r      = n[SHAMT_W-1:0];
      r_m1   = r - 5'd1;
      r_neg  = 5'd0 - r;
      n_zero = (n == 8'd0);
      n_big  = |n[7:5];
      n_eq32 = (n == 8'd32);
      is_rrx = (bus.shift_type == ROR) && !bus.instr4 && n_zero;
   end

   rotate_right32 u_rot (
      .x_i   (bus.x),
      .amt_i (r),
      .y_o   (rot_y)
   );

   // Result and carry selection: bypass, then zero-amount rules, then per type.
   always_comb begin
      y_d = bus.x;
      c_d = bus.carry;
      if (bus.not_shift) begin
         y_d = bus.x;
         c_d = bus.carry;
      end else if (is_rrx) begin
         y_d = {bus.carry, bus.x[31:1]};
         c_d = bus.x[0];
      end else if (n_zero) begin
         // LSR #0 / ASR #0 are true passthroughs here, not the #32 encodings.
         y_d = bus.x;
         c_d = bus.carry;
      end else begin
         case (bus.shift_type)
            LSL: begin
               if (n_big) begin
                  y_d = '0;
                  c_d = n_eq32 ? bus.x[0] : 1'b0;
               end else begin
                  y_d = bus.x << r;
                  c_d = bus.x[r_neg];
               end
            end
            LSR: begin
               if (n_big) begin
                  y_d = '0;
                  c_d = n_eq32 ? bus.x[31] : 1'b0;
               end else begin
                  y_d = bus.x >> r;
                  c_d = bus.x[r_m1];
               end
            end
            ASR: begin
               if (n_big) begin
                  y_d = {WORD_W{bus.x[31]}};
                  c_d = bus.x[31];
               end else begin
                  y_d = WORD_W'($signed(bus.x) >>> r);
                  c_d = bus.x[r_m1];
               end
            end
            default: begin
               // ROR: multiples of 32 leave the word intact but still
               // report bit 31 as the carry.
               if (r == 5'd0) begin
                  y_d = bus.x;
                  c_d = bus.x[31];
               end else begin
                  y_d = rot_y;
                  c_d = bus.x[r_m1];
               end
            end
         endcase
      end
   end

   // Pipelined copy of the shifter result for downstream stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q_q <= '0;
         c_q_q <= 1'b0;
      end else begin
         y_q_q <= y_d;
         c_q_q <= c_d;
      end
   end

   assign bus.y   = y_d;
   assign bus.c   = c_d;
   assign bus.y_q = y_q_q;
   assign bus.c_q = c_q_q;

endmodule

// File: tb/tb_shifter.sv
// tb/tb_shifter.sv - directed scoreboard bench for the operand-2 shifter
module tb_shifter;
   import shifter_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] y;
      logic        c;
   } exp_t;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;
   exp_t comb_q[$];
   exp_t reg_q[$];

   shifter_if sif ();

   shifter u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one request (called just after a falling edge), check the
   // combinational result, then the registered copy after the next rising edge.
   task automatic step(input string tag, input shift_type_t t, input logic [7:0] n,
                       input logic ns, input logic i4, input logic [31:0] xv,
                       input logic cin, input logic [31:0] ey, input logic ec);
      exp_t e;
      sif.shift_type = t;
      sif.shift_num  = n;
      sif.not_shift  = ns;
      sif.instr4     = i4;
      sif.x          = xv;
      sif.carry      = cin;
      e.tag = tag;
      e.y   = ey;
      e.c   = ec;
      comb_q.push_back(e);
      reg_q.push_back(e);
      #1;
      e = comb_q.pop_front();
      check32({e.tag, ".y"}, sif.y, e.y);
      check1({e.tag, ".c"}, sif.c, e.c);
      @(posedge clk);
      #1;
      e = reg_q.pop_front();
      check32({e.tag, ".y_q"}, sif.y_q, e.y);
      check1({e.tag, ".c_q"}, sif.c_q, e.c);
      @(negedge clk);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset          = 1'b1;
      sif.shift_type = LSL;
      sif.shift_num  = 8'd0;
      sif.not_shift  = 1'b0;
      sif.instr4     = 1'b0;
      sif.x          = 32'hDEADBEEF;
      sif.carry      = 1'b1;
      #1;
      check32("reset.y_q", sif.y_q, 32'h0);
      check1("reset.c_q", sif.c_q, 1'b0);
      @(posedge clk);
      #1;
      check32("reset_hold.y_q", sif.y_q, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      step("lsl0",  LSL, 8'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
      step("lsl1",  LSL, 8'd1,  1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1);
      step("lsl31", LSL, 8'd31, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1);
      step("lsr0",  LSR, 8'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
      step("lsr1",  LSR, 8'd1,  1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1);
      step("lsr31", LSR, 8'd31, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b1);
      step("asr0",  ASR, 8'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
      step("asr1",  ASR, 8'd1,  1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b1);
      step("asr31", ASR, 8'd31, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b1);
      step("asr31_neg", ASR, 8'd31, 1'b0, 1'b0, 32'h80000000, 1'b1, 32'hFFFFFFFF, 1'b0);
      step("rrx_a", ROR, 8'd0, 1'b0, 1'b0, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
      step("rrx_b", ROR, 8'd0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h80000000, 1'b0);
      step("ror1",  ROR, 8'd1,  1'b0, 1'b0, 32'h00000001, 1'b0, 32'h80000000, 1'b1);
      step("ror31", ROR, 8'd31, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1);
      step("ror_reg0", ROR, 8'd0, 1'b0, 1'b1, 32'h00000001, 1'b1, 32'h00000001, 1'b1);
      step("imm_hi_ignored", LSL, 8'hE1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1);
      step("lsl32", LSL, 8'd32,  1'b0, 1'b1, 32'h80000001, 1'b0, 32'h00000000, 1'b1);
      step("lsl33", LSL, 8'd33,  1'b0, 1'b1, 32'h80000001, 1'b1, 32'h00000000, 1'b0);
      step("lsr32", LSR, 8'd32,  1'b0, 1'b1, 32'h80000001, 1'b0, 32'h00000000, 1'b1);
      step("lsr40", LSR, 8'd40,  1'b0, 1'b1, 32'h80000001, 1'b1, 32'h00000000, 1'b0);
      step("asr200", ASR, 8'd200, 1'b0, 1'b1, 32'h80000001, 1'b0, 32'hFFFFFFFF, 1'b1);
      step("ror32", ROR, 8'd32,  1'b0, 1'b1, 32'h80000001, 1'b0, 32'h80000001, 1'b1);
      step("ror40", ROR, 8'd40,  1'b0, 1'b1, 32'h80000001, 1'b1, 32'h01800000, 1'b0);
      step("bypass", ROR, 8'd31, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1);

      // Mid-run reset pulse placed between clock edges.
      #2;
      reset = 1'b1;
      #1;
      check32("midreset.y_q", sif.y_q, 32'h0);
      check1("midreset.c_q", sif.c_q, 1'b0);
      check32("midreset.y_comb", sif.y, 32'h7FFFFFFF);
      @(posedge clk);
      #1;
      check32("midreset_hold.y_q", sif.y_q, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      step("post_reset", LSR, 8'd4, 1'b0, 1'b0, 32'h000000F8, 1'b0, 32'h0000000F, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
